// File: rtl/demux2_stream_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer: FSM encoding and default widths.
package demux2_stream_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE0 = 2'd1,
    ROUTE1 = 2'd2
  } state_e;

endpackage

// File: rtl/demux2_stream_if.sv
// Bundles the input channel and both output channels of demux2_stream.
// The master side is the environment (producer and consumers); the slave side is the demux.
interface demux2_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out0_data;
  logic             out0_last;
  logic             out0_valid;
  logic             out0_ready;

  logic [WIDTH-1:0] out1_data;
  logic             out1_last;
  logic             out1_valid;
  logic             out1_ready;

  modport master (
    output in_data, in_sel, in_last, in_valid,
    input  in_ready,
    input  out0_data, out0_last, out0_valid,
    output out0_ready,
    input  out1_data, out1_last, out1_valid,
    output out1_ready
  );

  modport slave (
    input  in_data, in_sel, in_last, in_valid,
    output in_ready,
    output out0_data, out0_last, out0_valid,
    input  out0_ready,
    output out1_data, out1_last, out1_valid,
    input  out1_ready
  );
endinterface

// File: rtl/demux2_stream_slot.sv
// One-entry output register stage: a load writes data/last and sets valid,
// a consumer handshake clears valid unless a load arrives in the same cycle.
module stream_slot
  import demux2_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);

  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      last_d  = last_i;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/demux2_stream.sv
// Streaming 1-to-2 demultiplexer: the first beat's select locks the destination for
// the whole packet; each output is a registered slot with a completed-packet counter.
module demux2_stream
  import demux2_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  demux2_stream_if.slave       bus,
  output logic [CNT_W-1:0]     pkt_cnt0,
  output logic [CNT_W-1:0]     pkt_cnt1
);

  state_e           state_q, state_d;
  logic             dest_sel;
  logic             in_ready;
  logic             xfer;
  logic             load0, load1;
  logic             out0_valid, out1_valid, out0_last, out1_last;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (xfer) begin
      if (bus.in_last)   state_d = IDLE;
      else if (dest_sel) state_d = ROUTE1;
      else               state_d = ROUTE0;
    end
  end

  // Select is only honoured in IDLE; once locked, the packet follows the state.
  always_comb begin
    dest_sel = 1'b0;
    case (state_q)
      ROUTE0:  dest_sel = 1'b0;
      ROUTE1:  dest_sel = 1'b1;
      default: dest_sel = bus.in_sel;
    endcase
    in_ready = dest_sel ? (!out1_valid || bus.out1_ready)
                        : (!out0_valid || bus.out0_ready);
    xfer  = bus.in_valid && in_ready;
    load0 = xfer && !dest_sel;
    load1 = xfer && dest_sel;
  end

  stream_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load0),
    .data_i  (bus.in_data),
    .last_i  (bus.in_last),
    .ready_i (bus.out0_ready),
    .valid_o (out0_valid),
    .data_o  (out0_data),
    .last_o  (out0_last)
  );

  stream_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load1),
    .data_i  (bus.in_data),
    .last_i  (bus.in_last),
    .ready_i (bus.out1_ready),
    .valid_o (out1_valid),
    .data_o  (out1_data),
    .last_o  (out1_last)
  );

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (out0_valid && bus.out0_ready && out0_last) cnt0_d = cnt0_q + CNT_W'(1);
    if (out1_valid && bus.out1_ready && out1_last) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out0_valid = out0_valid;
  assign bus.out0_data  = out0_data;
  assign bus.out0_last  = out0_last;
  assign bus.out1_valid = out1_valid;
  assign bus.out1_data  = out1_data;
  assign bus.out1_last  = out1_last;
  assign pkt_cnt0       = cnt0_q;
  assign pkt_cnt1       = cnt1_q;

endmodule

// File: tb/tb_demux2_stream.sv
// Directed bench for demux2_stream: a vector table for routing, locking, back-to-back
// and backpressure, plus hand-written reset-mid-packet and counter-wrap sequences.
module tb_demux2_stream;

  logic       clk;
  logic       reset;
  logic [7:0] cnt0, cnt1;
  int         checks;
  int         errors;
  logic       rdy_ok;

  demux2_stream_if #(.WIDTH(8)) bus ();

  demux2_stream #(.WIDTH(8), .CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .pkt_cnt0 (cnt0),
    .pkt_cnt1 (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sel, last, valid;
    logic [7:0] data;
    logic       r0, r1;
    logic       rdy;
    logic       v0;
    logic [7:0] d0;
    logic       l0, v1;
    logic [7:0] d1;
    logic       l1;
    logic [7:0] c0, c1;
  } vec_t;

  vec_t tbl [0:14];

  function automatic vec_t mk(input logic sel, last, valid, input logic [7:0] data,
                              input logic r0, r1, rdy, v0, input logic [7:0] d0,
                              input logic l0, v1, input logic [7:0] d1, input logic l1,
                              input logic [7:0] c0, c1);
    vec_t v;
    v.sel = sel; v.last = last; v.valid = valid; v.data = data;
    v.r0 = r0; v.r1 = r1; v.rdy = rdy;
    v.v0 = v0; v.d0 = d0; v.l0 = l0;
    v.v1 = v1; v.d1 = d1; v.l1 = l1;
    v.c0 = c0; v.c1 = c1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check in_ready before the edge and all outputs after it.
  task automatic apply(input vec_t v, input string tag);
    bus.in_sel     = v.sel;
    bus.in_last    = v.last;
    bus.in_valid   = v.valid;
    bus.in_data    = v.data;
    bus.out0_ready = v.r0;
    bus.out1_ready = v.r1;
    #1;
    chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, v.rdy});
    @(posedge clk);
    #1;
    chk({tag, ".out0_valid"}, {31'd0, bus.out0_valid}, {31'd0, v.v0});
    chk({tag, ".out0_data"},  {24'd0, bus.out0_data},  {24'd0, v.d0});
    chk({tag, ".out0_last"},  {31'd0, bus.out0_last},  {31'd0, v.l0});
    chk({tag, ".out1_valid"}, {31'd0, bus.out1_valid}, {31'd0, v.v1});
    chk({tag, ".out1_data"},  {24'd0, bus.out1_data},  {24'd0, v.d1});
    chk({tag, ".out1_last"},  {31'd0, bus.out1_last},  {31'd0, v.l1});
    chk({tag, ".pkt_cnt0"},   {24'd0, cnt0},           {24'd0, v.c0});
    chk({tag, ".pkt_cnt1"},   {24'd0, cnt1},           {24'd0, v.c1});
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.in_data = 8'h00; bus.in_sel = 1'b0; bus.in_last = 1'b0; bus.in_valid = 1'b0;
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;

    //        sel last vld data  r0 r1 rdy v0 d0    l0 v1 d1    l1 c0 c1
    tbl[0]  = mk(1, 1, 1, 8'hA5, 1, 1, 1, 0, 8'h00, 0, 1, 8'hA5, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0, 0, 8'hA5, 1, 0, 1);
    tbl[2]  = mk(0, 0, 1, 8'h11, 1, 1, 1, 1, 8'h11, 0, 0, 8'hA5, 1, 0, 1);
    tbl[3]  = mk(1, 0, 1, 8'h22, 1, 1, 1, 1, 8'h22, 0, 0, 8'hA5, 1, 0, 1);
    tbl[4]  = mk(1, 1, 1, 8'h33, 1, 1, 1, 1, 8'h33, 1, 0, 8'hA5, 1, 0, 1);
    tbl[5]  = mk(0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h33, 1, 0, 8'hA5, 1, 1, 1);
    tbl[6]  = mk(0, 0, 1, 8'h44, 1, 1, 1, 1, 8'h44, 0, 0, 8'hA5, 1, 1, 1);
    tbl[7]  = mk(1, 1, 1, 8'h55, 1, 1, 1, 1, 8'h55, 1, 0, 8'hA5, 1, 1, 1);
    tbl[8]  = mk(1, 1, 1, 8'h66, 1, 1, 1, 0, 8'h55, 1, 1, 8'h66, 1, 2, 1);
    tbl[9]  = mk(0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h55, 1, 0, 8'h66, 1, 2, 2);
    tbl[10] = mk(0, 0, 1, 8'h77, 0, 1, 1, 1, 8'h77, 0, 0, 8'h66, 1, 2, 2);
    tbl[11] = mk(1, 1, 1, 8'h88, 0, 1, 0, 1, 8'h77, 0, 0, 8'h66, 1, 2, 2);
    tbl[12] = mk(1, 1, 1, 8'h88, 0, 1, 0, 1, 8'h77, 0, 0, 8'h66, 1, 2, 2);
    tbl[13] = mk(1, 1, 1, 8'h88, 1, 1, 1, 1, 8'h88, 1, 0, 8'h66, 1, 2, 2);
    tbl[14] = mk(0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h88, 1, 0, 8'h66, 1, 3, 2);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst.out0_valid", {31'd0, bus.out0_valid}, 32'd0);
    chk("rst.out1_valid", {31'd0, bus.out1_valid}, 32'd0);
    chk("rst.out0_data",  {24'd0, bus.out0_data},  32'd0);
    chk("rst.out1_data",  {24'd0, bus.out1_data},  32'd0);
    chk("rst.out0_last",  {31'd0, bus.out0_last},  32'd0);
    chk("rst.out1_last",  {31'd0, bus.out1_last},  32'd0);
    chk("rst.pkt_cnt0",   {24'd0, cnt0},           32'd0);
    chk("rst.pkt_cnt1",   {24'd0, cnt1},           32'd0);
    chk("rst.in_ready",   {31'd0, bus.in_ready},   32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset after the second beat of a 4-beat out1 packet.
    apply(mk(1, 0, 1, 8'hA1, 1, 1, 1, 0, 8'h88, 1, 1, 8'hA1, 0, 3, 2), "mid.b1");
    apply(mk(0, 0, 1, 8'hA2, 1, 1, 1, 0, 8'h88, 1, 1, 8'hA2, 0, 3, 2), "mid.b2");
    do_reset();
    chk("mid.rst.out1_valid", {31'd0, bus.out1_valid}, 32'd0);
    chk("mid.rst.out1_data",  {24'd0, bus.out1_data},  32'd0);
    chk("mid.rst.out0_valid", {31'd0, bus.out0_valid}, 32'd0);
    chk("mid.rst.pkt_cnt0",   {24'd0, cnt0},           32'd0);
    chk("mid.rst.pkt_cnt1",   {24'd0, cnt1},           32'd0);
    apply(mk(0, 0, 1, 8'hA3, 1, 1, 1, 1, 8'hA3, 0, 0, 8'h00, 0, 0, 0), "mid.b3");
    apply(mk(1, 1, 1, 8'hA4, 1, 1, 1, 1, 8'hA4, 1, 0, 8'h00, 0, 0, 0), "mid.b4");
    apply(mk(0, 0, 0, 8'h00, 1, 1, 1, 0, 8'hA4, 1, 0, 8'h00, 0, 1, 0), "mid.idle");

    // 256 single-beat packets to out0 at full rate wrap the counter back to zero.
    do_reset();
    rdy_ok = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.in_sel = 1'b0; bus.in_last = 1'b1; bus.in_valid = 1'b1;
      bus.in_data = 8'(i);
      bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
      #1;
      if (bus.in_ready !== 1'b1) rdy_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("wrap.in_ready_always", {31'd0, rdy_ok}, 32'd1);
    chk("wrap.pkt_cnt0_255", {24'd0, cnt0}, 32'd255);
    chk("wrap.out0_data", {24'd0, bus.out0_data}, 32'hFF);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap.pkt_cnt0", {24'd0, cnt0}, 32'd0);
    chk("wrap.pkt_cnt1", {24'd0, cnt1}, 32'd0);
    chk("wrap.out0_valid", {31'd0, bus.out0_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux2_stream.md
# demux2_stream

Streaming 1-to-2 demultiplexer: routes packets from a single valid/ready input channel to one of two output channels, chosen by the select bit on each packet's first beat. It performs the inverse of the 2:1 select path; the steering decision is held for the whole packet and each output is registered. It sits between a shared producer and two downstream consumers in the datapath, with per-output completed-packet counters for debug.

## Interface
- WIDTH, 8, data beat width in bits
- CNT_W, 8, width of each packet counter
- clk  input  1  rising-edge clock, sole clock
- reset  input  1  synchronous, active-high reset
- in_data  input  WIDTH  input beat payload
- in_sel  input  1  destination (0 → out0, 1 → out1); sampled only on a packet's first beat
- in_last  input  1  marks final beat of packet
- in_valid  input  1  input beat present
- in_ready  output  1  block accepts beat this cycle (combinational)
- out0_data / out1_data  output  WIDTH  registered payload
- out0_last / out1_last  output  1  registered last flag
- out0_valid / out1_valid  output  1  output slot holds a beat
- out0_ready / out1_ready  input  1  consumer accepts beat
- pkt_cnt0 / pkt_cnt1  output  CNT_W  completed packets delivered on each output

## Operation
- FSM states: IDLE, ROUTE0, ROUTE1.
- Destination select: in IDLE it is in_sel; in ROUTEx it is x, and in_sel is ignored.
- in_ready is 1 when the destination slot is empty or its consumer is draining it this cycle (outX_valid=0 or outX_ready=1). An input transfer occurs when in_valid && in_ready.
- Transfers:
  - Accepted beat loads the destination slot: data, last, valid=1.
  - Accepted beat without last moves the FSM from IDLE to ROUTEx.
  - Accepted beat with last returns the FSM to IDLE. A single-beat packet never leaves IDLE.
- Each output slot clears valid on outX_valid && outX_ready unless reloaded in the same cycle. Simultaneous drain and load keeps valid=1 with the new beat.
- The non-destination slot drains independently and is never written.
- pkt_cntX increments by 1 on each output handshake with outX_last=1. It wraps 2^CNT_W−1 → 0.
- in_valid=0 never changes the FSM state. A stalled packet holds its lock indefinitely.
- Output data and last hold steady while valid=1 and ready=0.

## Timing
- Latency 1 cycle: a beat accepted at edge N appears on outX at N (valid high after edge N).
- Throughput 1 beat/cycle per packet when the consumer holds ready=1.
- Back-to-back packets: a packet ending at edge N allows the next first beat, with any in_sel, at edge N+1. No bubble.
- Reset (sync, high) forces the following:
  - FSM=IDLE.
  - outX_valid=0, outX_data=0, outX_last=0.
  - pkt_cnt0=pkt_cnt1=0.
- in_ready after reset is 1, because both slots are empty.
- Reset mid-packet discards buffered beats and the lock. Remaining beats of that packet are then treated as a new packet's first beat by the source's in_sel.

## Structure
- Shared package holds the FSM state encoding (IDLE=2'd0, ROUTE0=2'd1, ROUTE1=2'd2) and the default WIDTH/CNT_W.
- Sub-module `stream_slot`: a one-entry register stage with load/drain handshake and last flag. It is instantiated twice, once per output.
- Top level contains the FSM, the select steering, the in_ready mux and both counters.

## Test plan
- Single-beat routing: in_sel=1, in_data=8'hA5, in_last=1, out1_ready=1. Required: out1_valid=1 with 8'hA5 next cycle, out0_valid stays 0, pkt_cnt1=1 after the handshake.
- Lock test: 3-beat packet 8'h11, 8'h22, 8'h33 with in_sel=0,1,1. Required: all three beats on out0 in order, out1 untouched, pkt_cnt0=1.
- Backpressure: out0_ready=0 while a packet streams to out0. Required:
  - in_ready drops after the first beat.
  - out0_data is held.
  - Releasing ready resumes with no loss or duplication.
- Back-to-back: packet A (2 beats → out0) immediately followed by packet B (1 beat → out1), ready high throughout. Required: in_ready=1 every cycle, B appears on out1 the cycle after A's last beat is accepted.
- Counter wrap: 256 single-beat packets to out0. Required: pkt_cnt0 reads 0 and pkt_cnt1 reads 0.
- Reset mid-packet: assert reset after the 2nd beat of a 4-beat out1 packet. Required:
  - Next cycle out1_valid=0, state IDLE, counters 0.
  - The following beat with in_sel=0 lands on out0.
